// File: rtl/fnd_pkg.sv
// Shared definitions for the FND digit logic: BCD digit width, limits and the
// converter FSM state encoding.
package fnd_pkg;
  localparam int       DW      = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_mac10.sv
// Combinational y = a*10 + d using shift-add only; the sum is formed BW+4 bits
// wide and truncated to BW.
module bcd_mac10
  import fnd_pkg::*;
#(
  parameter int BW = 10
) (
  input  logic [BW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [BW-1:0] y
);
  logic [BW+3:0] a_w, sum;

  assign a_w = {4'b0, a};
  assign sum = (a_w << 3) + (a_w << 1) + {{BW{1'b0}}, d};
  assign y   = sum[BW-1:0];
endmodule

// File: rtl/bcd2bin_seq.sv
// Multi-cycle packed-BCD to binary converter: Horner evaluation, one digit per
// clock, MSD first. Invalid digits force a zero result with oERR set.
module bcd2bin_seq
  import fnd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iSTART,
  input  logic [4*NDIG-1:0]  iBCD,
  output logic               oBUSY,
  output logic               oDONE,
  output logic [BW-1:0]      oBIN,
  output logic               oERR
);
  localparam int CW = $clog2(NDIG + 1);

  state_t            state, state_nx;
  logic [DW*NDIG-1:0] sreg;
  logic [BW-1:0]      acc, acc_nx;
  logic [CW-1:0]      cnt;
  logic               err_q, bad_in, last;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (iBCD[i*DW +: DW] > BCD_MAX) bad_in = 1'b1;
  end

  assign last = (cnt == CW'(NDIG - 1));

  bcd_mac10 #(.BW(BW)) u_mac (
    .a (acc),
    .d (sreg[DW*NDIG-1 -: DW]),
    .y (acc_nx)
  );

  always_ff @(posedge iCLK or negedge iRSTn)
    if (!iRSTn) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (iSTART) state_nx = ST_CONV;
      ST_CONV: if (last)   state_nx = ST_DONE;
      ST_DONE:             state_nx = ST_IDLE;
      default:             state_nx = ST_IDLE;
    endcase
  end

  // Datapath; the result registers load on the final CONV edge so they are
  // already valid during the DONE cycle.
  always_ff @(posedge iCLK or negedge iRSTn)
    if (!iRSTn) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      oBIN  <= '0;
      oERR  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (iSTART) begin
          sreg  <= iBCD;
          acc   <= '0;
          cnt   <= '0;
          err_q <= bad_in;
        end
        ST_CONV: begin
          acc  <= acc_nx;
          sreg <= sreg << DW;
          cnt  <= cnt + CW'(1);
          if (last) begin
            oBIN <= err_q ? '0 : acc_nx;
            oERR <= err_q;
          end
        end
        default: ;
      endcase
    end

  assign oBUSY = (state == ST_CONV);
  assign oDONE = (state == ST_DONE);
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq (NDIG=3, BW=10): vector table, exhaustive
// valid sweep, held-start throughput and mid-conversion reset.
module tb_bcd2bin_seq;
  logic        iCLK = 1'b0;
  logic        iRSTn, iSTART;
  logic [11:0] iBCD;
  logic        oBUSY, oDONE, oERR;
  logic [9:0]  oBIN;

  int total = 0;
  int bad   = 0;

  bcd2bin_seq #(.NDIG(3), .BW(10)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iSTART(iSTART), .iBCD(iBCD),
    .oBUSY(oBUSY), .oDONE(oDONE), .oBIN(oBIN), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_conv(input logic [11:0] bcd, output logic [9:0] bin,
                          output logic err, output int lat, output logic busy_ok);
    iBCD = bcd; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    iBCD = ~bcd;
    lat = 1; busy_ok = 1'b1;
    while (!oDONE && lat < 20) begin
      if (!oBUSY) busy_ok = 1'b0;
      @(negedge iCLK);
      lat++;
    end
    bin = oBIN; err = oERR;
    if (oBUSY) busy_ok = 1'b0;
    @(negedge iCLK);
  endtask

  initial begin
    vec_t vecs[7];
    logic [9:0] bin;
    logic err, bok;
    int lat, ndone, last_done;
    logic [11:0] b;

    vecs[0] = '{12'h255, 10'd255, 1'b0};
    vecs[1] = '{12'h000, 10'd0,   1'b0};
    vecs[2] = '{12'h999, 10'd999, 1'b0};
    vecs[3] = '{12'h009, 10'd9,   1'b0};
    vecs[4] = '{12'h100, 10'd100, 1'b0};
    vecs[5] = '{12'h1A3, 10'd0,   1'b1};
    vecs[6] = '{12'h042, 10'd42,  1'b0};

    iRSTn = 1'b0; iSTART = 1'b0; iBCD = '0;
    #1;
    check("reset_outs", {oBUSY, oDONE, oERR, oBIN}, 0);
    repeat (2) @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);

    foreach (vecs[i]) begin
      run_conv(vecs[i].bcd, bin, err, lat, bok);
      check($sformatf("lat_%03h", vecs[i].bcd), lat, 4);
      check($sformatf("busy_%03h", vecs[i].bcd), bok, 1);
      check($sformatf("bin_%03h", vecs[i].bcd), bin, vecs[i].bin);
      check($sformatf("err_%03h", vecs[i].bcd), err, vecs[i].err);
    end

    for (int v = 0; v < 1000; v++) begin
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run_conv(b, bin, err, lat, bok);
      check($sformatf("sweep_%0d", v), {lat[7:0], err, bin}, {8'd4, 1'b0, 10'(v)});
    end

    // iSTART held high: iBCD is scrambled while busy and must not leak in.
    iBCD = 12'h123; iSTART = 1'b1;
    ndone = 0; last_done = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge iCLK);
      if (oDONE) begin
        ndone++;
        check("held_bin", oBIN, 123);
        check("held_gap", c - last_done, (ndone == 1) ? 4 : 5);
        last_done = c;
      end
      iBCD = oBUSY ? 12'h456 : 12'h123;
    end
    check("held_count", ndone, 4);
    iSTART = 1'b0;
    repeat (6) @(negedge iCLK);

    // Reset on the second CONV cycle aborts with no DONE.
    iBCD = 12'h777; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    @(negedge iCLK);
    check("pre_rst_busy", oBUSY, 1);
    iRSTn = 1'b0;
    #1;
    check("mid_rst_outs", {oBUSY, oDONE, oERR, oBIN}, 0);
    @(negedge iCLK);
    iRSTn = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge iCLK);
      if (oDONE || oBUSY) ndone++;
    end
    check("no_done_after_rst", ndone, 0);

    run_conv(12'h321, bin, err, lat, bok);
    check("post_rst_lat", lat, 4);
    check("post_rst_bin", bin, 321);
    check("post_rst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
